// File: rtl/proc_pkg.sv
// proc_pkg: phase-sequencer states and opcode constants shared with the control decoder
package proc_pkg;
  localparam int NUM_PHASES = 5;
  localparam logic [1:0] OP_ALU = 2'b11;
  localparam logic [3:0] ALU_HLT = 4'b1111;
  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, P4} state_t;
endpackage

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: run-control, IR, ALU-flag and phase/status bundle of the phase sequencer
interface phase_sequencer_if import proc_pkg::*; #(parameter int CNT_W = 16);
`ifdef PHASE_SEQ_SINGLE_STEP_EN
  logic step_req;
`endif
  logic exec_req;
  logic [15:0] instruction;
  logic flag_we;
  logic alu_s, alu_z, alu_c, alu_v;
  logic [NUM_PHASES-1:0] phase;
  logic p0, exec, pc_e;
  logic S, Z, C, V;
  logic halted;
  logic [CNT_W-1:0] instr_count;
  modport master (
`ifdef PHASE_SEQ_SINGLE_STEP_EN
    output step_req,
`endif
    output exec_req, instruction, flag_we, alu_s, alu_z, alu_c, alu_v,
    input phase, p0, exec, pc_e, S, Z, C, V, halted, instr_count
  );
  modport slave (
`ifdef PHASE_SEQ_SINGLE_STEP_EN
    input step_req,
`endif
    input exec_req, instruction, flag_we, alu_s, alu_z, alu_c, alu_v,
    output phase, p0, exec, pc_e, S, Z, C, V, halted, instr_count
  );
endinterface

// File: rtl/phase_sequencer_flag_reg.sv
// flag_reg: S/Z/C/V condition-flag register with load enable
module flag_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 4'b0;
    else if (load) q <= d;
endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: run/stop control and five-phase sequencer; PHASE_SEQ_SINGLE_STEP_EN adds step_req
module phase_sequencer import proc_pkg::*; #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst,
  phase_sequencer_if.slave bus
);
  state_t state, state_nx;
  logic hlt, stop, halted, single, start, is_hlt;
  logic [CNT_W-1:0] count;
  logic [3:0] flags;
  assign is_hlt = bus.instruction[15:14] == OP_ALU && bus.instruction[7:4] == ALU_HLT;
`ifdef PHASE_SEQ_SINGLE_STEP_EN
  assign start = bus.exec_req | bus.step_req;
  // a single-step run ends after its P4; exec_req wins when both arrive together
  always_ff @(posedge clk or negedge rst)
    if (!rst) single <= 1'b0;
    else if (state == IDLE) single <= bus.step_req & ~bus.exec_req;
`else
  assign start = bus.exec_req;
  assign single = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? P0 : IDLE;
      P0: state_nx = P1;
      P1: state_nx = P2;
      P2: state_nx = P3;
      P3: state_nx = P4;
      P4: state_nx = (hlt | stop | bus.exec_req | single) ? IDLE : P0;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      hlt <= 1'b0;
      stop <= 1'b0;
      halted <= 1'b0;
      count <= '0;
    end else begin
      state <= state_nx;
      hlt <= (state == P1) ? is_hlt : (state == P4) ? 1'b0 : hlt;
      stop <= (state != IDLE) & (stop | bus.exec_req);
      halted <= (state == P4 && hlt) ? 1'b1 : (state == IDLE && bus.exec_req) ? 1'b0 : halted;
      if (state == P4) count <= count + 1'b1;
    end
  flag_reg u_flag_reg (
    .clk(clk),
    .rst(rst),
    .load(bus.flag_we && state == P2),
    .d({bus.alu_s, bus.alu_z, bus.alu_c, bus.alu_v}),
    .q(flags)
  );
  assign bus.phase = {state == P4, state == P3, state == P2, state == P1, state == P0};
  assign bus.p0 = state == P0;
  assign bus.exec = state != IDLE;
  assign bus.pc_e = state == P4;
  assign {bus.S, bus.Z, bus.C, bus.V} = flags;
  assign bus.halted = halted;
  assign bus.instr_count = count;
endmodule
